// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding a UART core one frame at a time.
// Holds data/enable for the whole frame and paces frames on the core's done edge.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [7:0]            wr_data_i,
    input  logic                  wr_en_i,
    input  logic                  clr_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  overflow_o,
    output logic                  busy_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_start_o,
    input  logic                  tx_done_i
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_d;
    logic            done_prev_q;
    logic            push, pop, done_rise, start_d;

    // Next-state, pop decision and FIFO occupancy; full test uses the registered flag
    always_comb begin
        push      = wr_en_i && !full_o;
        done_rise = tx_done_i && !done_prev_q;
        state_d   = state_q;
        pop       = 1'b0;
        start_d   = tx_start_o;
        case (state_q)
            IDLE: begin
                start_d = 1'b0;
                if (!empty_o) begin
                    pop     = 1'b1;
                    start_d = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (done_rise) begin
                    start_d = 1'b0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                start_d = 1'b0;
                if (!tx_done_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        count_d = count_o + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_o     <= '0;
            empty_o     <= 1'b1;
            full_o      <= 1'b0;
            overflow_o  <= 1'b0;
            busy_o      <= 1'b0;
            tx_start_o  <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            done_prev_q <= tx_done_i;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (wr_en_i && full_o) begin
                overflow_o <= 1'b1;
            end
            count_o    <= count_d;
            empty_o    <= (count_d == '0);
            full_o     <= (count_d == CW'(DEPTH));
            busy_o     <= (state_d != IDLE);
            tx_start_o <= start_d;
        end
    end

    // Frame byte survives flush; only reset zeroes it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_data_o <= 8'h00;
        end else if (!clr_i && pop) begin
            tx_data_o <= mem[rd_ptr_q];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !rst_i && !clr_i) begin
            mem[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed table-driven bench for uart_tx_fifo plus hand-written burst, overflow and flush sequences.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst, clr, wr_en, done;
    logic [7:0] wr_data;
    logic       full, empty, ovf, busy, start;
    logic [4:0] count;
    logic [7:0] tx_data;

    int vec_cnt = 0;
    int err_cnt = 0;

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .wr_data_i  (wr_data),
        .wr_en_i    (wr_en),
        .clr_i      (clr),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count),
        .overflow_o (ovf),
        .busy_o     (busy),
        .tx_data_o  (tx_data),
        .tx_start_o (start),
        .tx_done_i  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       clr;
        logic       wr_en;
        logic       done;
        logic [7:0] wr_data;
        logic       exp_start;
        logic [7:0] exp_data;
        logic [4:0] exp_count;
        logic       exp_empty;
        logic       exp_full;
        logic       exp_busy;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [17];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, ".start"}, 32'(start), 32'(v.exp_start));
        chk({tag, ".data"},  32'(tx_data), 32'(v.exp_data));
        chk({tag, ".count"}, 32'(count), 32'(v.exp_count));
        chk({tag, ".empty"}, 32'(empty), 32'(v.exp_empty));
        chk({tag, ".full"},  32'(full), 32'(v.exp_full));
        chk({tag, ".busy"},  32'(busy), 32'(v.exp_busy));
        chk({tag, ".ovf"},   32'(ovf), 32'(v.exp_ovf));
    endtask

    initial begin
        logic [7:0] exp_q [$];
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; done = 1'b0; wr_data = 8'h00;

        //          rst   clr   wr    done  wdata  start data   cnt   emp   full  busy  ovf
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'hA5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'hA5, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        // Random data/strobes under reset must not disturb reset values
        for (int i = 0; i < 3; i++) begin
            vecs[i].wr_data = 8'($urandom);
            vecs[i].wr_en   = 1'($urandom);
            vecs[i].done    = 1'($urandom);
        end

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            rst = vecs[i].rst; clr = vecs[i].clr; wr_en = vecs[i].wr_en;
            done = vecs[i].done; wr_data = vecs[i].wr_data;
            cyc();
            chk_all($sformatf("vec%0d", i), vecs[i]);
        end
        rst = 1'b0; clr = 1'b0; wr_en = 1'b0; done = 1'b0;

        // Park the FSM in SEND, then fill to full and overflow by one
        wr_en = 1'b1; wr_data = 8'hEE; cyc();
        wr_en = 1'b0; cyc();
        chk("burst.first_start", 32'(start), 32'd1);
        chk("burst.first_data", 32'(tx_data), 32'hEE);
        exp_q.push_back(8'hEE);
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); cyc();
            exp_q.push_back(8'(i));
        end
        chk("burst.count16", 32'(count), 32'd16);
        chk("burst.full", 32'(full), 32'd1);
        chk("burst.no_ovf", 32'(ovf), 32'd0);
        wr_data = 8'h99; cyc();
        wr_en = 1'b0;
        chk("ovf.set", 32'(ovf), 32'd1);
        chk("ovf.count", 32'(count), 32'd16);
        chk("ovf.full", 32'(full), 32'd1);

        // Behavioural core: hold done low a while, pulse it, release
        for (int f = 0; f < 17; f++) begin
            int n = 0;
            while (!start && n < 20) begin
                cyc();
                n++;
            end
            chk($sformatf("drain.start%0d", f), 32'(start), 32'd1);
            chk($sformatf("drain.byte%0d", f), 32'(tx_data), 32'(exp_q[f]));
            cyc(); cyc();
            chk($sformatf("drain.hold%0d", f), 32'(start), 32'd1);
            done = 1'b1; cyc();
            chk($sformatf("drain.release%0d", f), 32'(start), 32'd0);
            done = 1'b0; cyc();
        end
        cyc(); cyc();
        chk("drain.idle_start", 32'(start), 32'd0);
        chk("drain.empty", 32'(empty), 32'd1);
        chk("drain.busy", 32'(busy), 32'd0);
        chk("ovf.sticky", 32'(ovf), 32'd1);
        clr = 1'b1; cyc();
        clr = 1'b0;
        chk("ovf.clr", 32'(ovf), 32'd0);
        chk("clr.data_hold", 32'(tx_data), 32'h10);

        // Mid-frame flush with five bytes queued and a colliding write
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'h50 + 8'(i); cyc();
        end
        wr_en = 1'b0;
        chk("flush.pre_count", 32'(count), 32'd5);
        chk("flush.pre_start", 32'(start), 32'd1);
        chk("flush.pre_data", 32'(tx_data), 32'h50);
        clr = 1'b1; wr_en = 1'b1; wr_data = 8'h77; cyc();
        clr = 1'b0; wr_en = 1'b0;
        chk_all("flush", '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        cyc();
        chk_all("flush.after", '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h50, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        // Reset mid-frame zeroes the data byte as well
        wr_en = 1'b1; wr_data = 8'hC3; cyc();
        wr_en = 1'b0; cyc();
        chk("rst.pre_data", 32'(tx_data), 32'hC3);
        rst = 1'b1; clr = 1'b1; cyc();
        rst = 1'b0; clr = 1'b0;
        chk_all("rst.mid", '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
